// File: rtl/call_return_pkg.sv
// Shared types for the call/return sequencer: FSM states, fault codes and default sizes.
package call_return_pkg;

  localparam int DEF_AW    = 12;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_SETUP,
    PUSH_PULSE,
    POP_PULSE,
    POP_HOLD,
    LOAD,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_OVF   = 2'b01,
    FLT_UNF   = 2'b10,
    FLT_PROTO = 2'b11
  } fault_t;

endpackage

// File: rtl/call_return_ctrl.sv
// Drives push/pop handshakes to the return-address stack and redirects fetch; request to PCLoad is 3 cycles.
// No queuing: requests seen while Busy are dropped, and the requester holds Call/Ret until PCLoad.
module call_return_ctrl
  import call_return_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Call,
  input  logic                   Ret,
  input  logic [AW-1:0]          PC,
  input  logic [AW-1:0]          Target,
  output logic [AW-1:0]          StkDataOut,
  input  logic [AW-1:0]          StkDataIn,
  output logic                   StkPush,
  output logic                   StkPop,
  output logic                   StkReset,
  input  logic                   StkErr,
  output logic [AW-1:0]          NextPC,
  output logic                   PCLoad,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Depth,
  output logic                   Fault,
  output logic [1:0]             FaultCode
);

  localparam int DW = $clog2(DEPTH) + 1;

  state_t        state_q, state_d;
  fault_t        flt_q, flt_d;
  logic          accept_call;
  logic          push_q, pop_q, pcload_q;
  logic [DW-1:0] depth_q;
  logic [AW-1:0] dout_q, nextpc_q;

  always_comb begin
    state_d     = state_q;
    flt_d       = flt_q;
    accept_call = 1'b0;
    case (state_q)
      IDLE: begin
        if (Call && Ret) begin
          state_d = FAULT;
          flt_d   = FLT_PROTO;
        end else if (Call) begin
          if (depth_q == DW'(DEPTH)) begin
            state_d = FAULT;
            flt_d   = FLT_OVF;
          end else begin
            state_d     = PUSH_SETUP;
            accept_call = 1'b1;
          end
        end else if (Ret) begin
          if (depth_q == '0) begin
            state_d = FAULT;
            flt_d   = FLT_UNF;
          end else begin
            state_d = POP_PULSE;
          end
        end
      end
      PUSH_SETUP: state_d = PUSH_PULSE;
      PUSH_PULSE: state_d = LOAD;
      POP_PULSE:  state_d = POP_HOLD;
      POP_HOLD:   state_d = LOAD;
      LOAD: begin
        // A stack error during the load still lets the redirect and depth update land.
        if (StkErr) begin
          state_d = FAULT;
          flt_d   = FLT_PROTO;
        end else begin
          state_d = IDLE;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      flt_q    <= FLT_NONE;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      pcload_q <= 1'b0;
      depth_q  <= '0;
      dout_q   <= '0;
      nextpc_q <= '0;
    end else begin
      state_q  <= state_d;
      flt_q    <= flt_d;
      // Strobes are decoded from the next state so they come straight off flops.
      push_q   <= (state_d == PUSH_PULSE);
      pop_q    <= (state_d == POP_PULSE) || (state_d == POP_HOLD);
      pcload_q <= (state_d == LOAD);
      if (accept_call) begin
        dout_q   <= PC + AW'(1);
        nextpc_q <= Target;
      end
      if (state_q == POP_HOLD) begin
        nextpc_q <= StkDataIn;
      end
      // Depth moves on entry to LOAD so it is already current while PCLoad is high.
      if (state_q == PUSH_PULSE) begin
        depth_q <= depth_q + DW'(1);
      end else if (state_q == POP_HOLD) begin
        depth_q <= depth_q - DW'(1);
      end
    end
  end

  assign StkDataOut = dout_q;
  assign StkPush    = push_q;
  assign StkPop     = pop_q;
  assign StkReset   = Reset;
  assign NextPC     = nextpc_q;
  assign PCLoad     = pcload_q;
  assign Busy       = (state_q != IDLE);
  assign Depth      = depth_q;
  assign Fault      = (state_q == FAULT);
  assign FaultCode  = flt_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Bench for call_return_ctrl: directed table, hand sequences and random traffic against a transaction-level model.
module tb_call_return_ctrl;

  localparam int AW    = 12;
  localparam int DEPTH = 8;

  logic          Clk = 1'b0;
  logic          Reset, Call, Ret, StkErr;
  logic [AW-1:0] PC, Target, StkDataIn;
  logic [AW-1:0] StkDataOut, NextPC;
  logic          StkPush, StkPop, StkReset, PCLoad, Busy, Fault;
  logic [3:0]    Depth;
  logic [1:0]    FaultCode;

  int checks = 0;
  int errors = 0;

  call_return_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Call(Call), .Ret(Ret), .PC(PC), .Target(Target),
    .StkDataOut(StkDataOut), .StkDataIn(StkDataIn), .StkPush(StkPush), .StkPop(StkPop),
    .StkReset(StkReset), .StkErr(StkErr), .NextPC(NextPC), .PCLoad(PCLoad), .Busy(Busy),
    .Depth(Depth), .Fault(Fault), .FaultCode(FaultCode)
  );

  always #5 Clk = ~Clk;

  // Behavioural stack device: pushes on a Push cycle, retires the top once a Pop burst ends.
  logic [AW-1:0] dev_stk[$];
  logic          pop_prev = 1'b0;
  initial StkDataIn = '0;
  always @(negedge Clk) begin
    if (StkReset) begin
      dev_stk.delete();
    end else begin
      if (StkPush) dev_stk.push_back(StkDataOut);
      if (pop_prev && !StkPop && dev_stk.size() > 0) void'(dev_stk.pop_back());
    end
    pop_prev  = StkPop;
    StkDataIn = (dev_stk.size() > 0) ? dev_stk[$] : '0;
  end

  // Transaction-level reference state.
  int            m_depth;
  bit            m_fault;
  logic [1:0]    m_code;
  logic [AW-1:0] m_next, m_dout;
  logic [AW-1:0] ref_stk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_depth = 0; m_fault = 0; m_code = 2'b00; m_next = '0; m_dout = '0;
    ref_stk.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1; Call = 1'b0; Ret = 1'b0; StkErr = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_clear();
    check("rst_busy", Busy, 0);
  endtask

  // Issues one request from IDLE, observes cycles 1..4 and scores against the model.
  task automatic do_req(input bit c, input bit r, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                        input bit err, output logic [AW-1:0] o_next, output logic [3:0] o_depth,
                        output logic [1:0] o_code);
    int            kind;  // 0 none, 1 call, 2 return, 3 new fault, 4 ignored
    logic [1:0]    nc;
    logic [3:0]    p_push, p_pop, p_ld, p_busy, e_push, e_pop, e_ld, e_busy;
    logic [AW-1:0] d1, d2, nx3, dout4;
    logic [3:0]    dep3, dep4;
    logic          flt4;
    logic [1:0]    code4;
    bit            eff_err;
    nc = 2'b00;
    if (m_fault)          kind = 4;
    else if (c && r)      begin kind = 3; nc = 2'b11; end
    else if (c)           begin if (m_depth == DEPTH) begin kind = 3; nc = 2'b01; end else kind = 1; end
    else if (r)           begin if (m_depth == 0) begin kind = 3; nc = 2'b10; end else kind = 2; end
    else                  kind = 0;
    eff_err = err && (kind == 1 || kind == 2);
    d1 = '0; d2 = '0; nx3 = '0; dout4 = '0; dep3 = '0; dep4 = '0; flt4 = 1'b0; code4 = '0;
    Call = c; Ret = r; PC = pc; Target = tgt; StkErr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clk); #1;
      p_push[i-1] = StkPush; p_pop[i-1] = StkPop; p_ld[i-1] = PCLoad; p_busy[i-1] = Busy;
      if (i == 1) d1 = StkDataOut;
      if (i == 2) d2 = StkDataOut;
      if (i == 3) begin nx3 = NextPC; dep3 = Depth; Call = 1'b0; Ret = 1'b0; StkErr = eff_err; end
      if (i == 4) begin dep4 = Depth; flt4 = Fault; code4 = FaultCode; dout4 = StkDataOut; StkErr = 1'b0; end
    end
    e_push = 4'b0000; e_pop = 4'b0000; e_ld = 4'b0000; e_busy = 4'b0000;
    case (kind)
      1: begin
        m_dout = pc + 12'd1; ref_stk.push_back(m_dout); m_next = tgt; m_depth++;
        e_push = 4'b0010; e_ld = 4'b0100; e_busy = 4'b0111;
      end
      2: begin
        m_next = ref_stk.pop_back(); m_depth--;
        e_pop = 4'b0011; e_ld = 4'b0100; e_busy = 4'b0111;
      end
      3: begin m_fault = 1'b1; m_code = nc; e_busy = 4'b1111; end
      4: e_busy = 4'b1111;
      default: ;
    endcase
    if (eff_err) begin m_fault = 1'b1; m_code = 2'b11; e_busy = 4'b1111; end
    check("push_cycles", p_push, e_push);
    check("pop_cycles", p_pop, e_pop);
    check("pcload_cycles", p_ld, e_ld);
    check("busy_cycles", p_busy, e_busy);
    check("nextpc_at_load", nx3, m_next);
    check("depth_at_load", dep3, m_depth);
    check("depth_after", dep4, m_depth);
    check("fault_after", flt4, m_fault);
    check("faultcode_after", code4, m_code);
    check("dout_held", dout4, m_dout);
    if (kind == 1) begin
      check("dout_setup", d1, m_dout);
      check("dout_pulse", d2, m_dout);
    end
    o_next = nx3; o_depth = dep4; o_code = code4;
  endtask

  typedef struct {
    bit            rst;
    bit            call;
    bit            ret;
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    bit            err;
    logic [AW-1:0] exp_next;
    logic [3:0]    exp_depth;
    logic [1:0]    exp_code;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [AW-1:0] o_next;
    logic [3:0]    o_depth;
    logic [1:0]    o_code;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 12'h010, 12'h200, 1'b0, 12'h200, 4'd1, 2'b00};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 12'h011, 4'd0, 2'b00};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 12'h123, 1'b0, 12'h123, 4'd1, 2'b00};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 2'b00};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0, 2'b10};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 12'h050, 12'h060, 1'b0, 12'h000, 4'd0, 2'b11};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 12'h100, 12'h300, 1'b1, 12'h300, 4'd1, 2'b11};

    Reset = 1'b1; Call = 1'b0; Ret = 1'b0; PC = '0; Target = '0; StkErr = 1'b0;
    model_clear();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_stkreset", StkReset, 1);
    check("rst_push", StkPush, 0);
    check("rst_pop", StkPop, 0);
    check("rst_pcload", PCLoad, 0);
    check("rst_busy", Busy, 0);
    check("rst_fault", Fault, 0);
    check("rst_code", FaultCode, 0);
    check("rst_depth", Depth, 0);
    check("rst_nextpc", NextPC, 0);
    check("rst_dout", StkDataOut, 0);
    Reset = 1'b0;
    #1;
    check("stkreset_follows", StkReset, 0);

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      do_req(tbl[k].call, tbl[k].ret, tbl[k].pc, tbl[k].tgt, tbl[k].err, o_next, o_depth, o_code);
      check($sformatf("tbl%0d_nextpc", k), o_next, tbl[k].exp_next);
      check($sformatf("tbl%0d_depth", k), o_depth, tbl[k].exp_depth);
      check($sformatf("tbl%0d_code", k), o_code, tbl[k].exp_code);
    end

    // Fill the stack, overflow it, then confirm the fault is absorbing.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b1, 1'b0, 12'(16 * i + 3), 12'(256 + i), 1'b0, o_next, o_depth, o_code);
    end
    check("full_depth", o_depth, DEPTH);
    do_req(1'b1, 1'b0, 12'h555, 12'h666, 1'b0, o_next, o_depth, o_code);
    check("ovf_code", o_code, 2'b01);
    check("ovf_fault", Fault, 1);
    do_req(1'b0, 1'b1, 12'h000, 12'h000, 1'b0, o_next, o_depth, o_code);
    do_req(1'b1, 1'b0, 12'h001, 12'h002, 1'b0, o_next, o_depth, o_code);
    check("ovf_sticky_depth", o_depth, DEPTH);

    // Reset landing in POP_HOLD.
    do_reset();
    do_req(1'b1, 1'b0, 12'h400, 12'h500, 1'b0, o_next, o_depth, o_code);
    Ret = 1'b1;
    @(posedge Clk); #1;
    check("mid_pop_c1", StkPop, 1);
    @(posedge Clk); #1;
    check("mid_pop_c2", StkPop, 1);
    Reset = 1'b1;
    #1;
    check("mid_pop_stkreset", StkReset, 1);
    @(posedge Clk); #1;
    check("mid_pop_rst_pop", StkPop, 0);
    check("mid_pop_rst_pcload", PCLoad, 0);
    check("mid_pop_rst_depth", Depth, 0);
    check("mid_pop_rst_busy", Busy, 0);
    check("mid_pop_rst_fault", Fault, 0);
    Reset = 1'b0; Ret = 1'b0;
    model_clear();
    do_req(1'b1, 1'b0, 12'h7A0, 12'h111, 1'b0, o_next, o_depth, o_code);
    check("post_rst_call_next", o_next, 12'h111);

    // Random traffic scored by the model.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      int op;
      bit rc, rr;
      if (m_fault && $urandom_range(0, 2) == 0) do_reset();
      op = int'($urandom_range(0, 19));
      rc = (op < 9) || (op == 17);
      rr = (op >= 9 && op < 17) || (op == 17);
      do_req(rc, rr, 12'($urandom), 12'($urandom), ($urandom_range(0, 29) == 0), o_next, o_depth, o_code);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
